// File: rtl/aes_key_expander_seq.sv
// AES-128/192/256 key schedule: one word per cycle into a 4*(Nr+1)-word store, indexed round-key read port.
// Latency: start to done is 42/48/54 cycles; start is ignored unless idle (no queueing); rk_data lags rk_idx by 1 cycle.
module aes_key_expander_seq #(
  parameter int MAX_KEY_WORDS = 8,
  parameter int MAX_ROUNDS    = 14
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   key_len,
  input  logic [32*MAX_KEY_WORDS-1:0]  cipher_key,
  output logic                         busy,
  output logic                         done,
  output logic                         keys_valid,
  output logic                         err,
  output logic [3:0]                   num_rounds,
  input  logic [3:0]                   rk_idx,
  output logic [127:0]                 rk_data
);

  localparam int DEPTH = 4 * (MAX_ROUNDS + 1);

  // Byte a of the S-box lives at bit offset (255-a)*8, i.e. row-major with entry 0 leftmost.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TBL[{~a, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  state_t state, state_nx;
  logic   accept, illegal, last_word;

  logic [3:0]  nk_q, nr_q;
  logic [2:0]  nk_m1;
  logic [5:0]  i_q, last_idx;
  logic [2:0]  wrap_q;
  logic [7:0]  rcon_q;
  logic [32*MAX_KEY_WORDS-1:0] key_q;
  logic [31:0] key_w [MAX_KEY_WORDS];
  logic [31:0] win_q [MAX_KEY_WORDS];
  logic [31:0] mem   [DEPTH];

  logic [31:0] last_w, prev_w, sub_in, sub_out, temp, new_word;

  assign nk_m1     = nk_q[2:0] - 3'd1;
  assign last_idx  = {nr_q, 2'b00} + 6'd3;
  assign last_word = (i_q == last_idx);

  always_comb begin
    for (int j = 0; j < MAX_KEY_WORDS; j++) begin
      key_w[j] = key_q[32*(MAX_KEY_WORDS-1-j) +: 32];
    end
  end

  // win_q[0] is w[i-1] and win_q[Nk-1] is w[i-Nk]; the store itself is never read while expanding.
  always_comb begin
    last_w  = win_q[0];
    prev_w  = win_q[nk_m1];
    sub_in  = (wrap_q == 3'd0) ? {last_w[23:0], last_w[31:24]} : last_w;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    temp    = last_w;
    if (wrap_q == 3'd0) begin
      temp = sub_out ^ {rcon_q, 24'h0};
    end else if (nk_q == 4'd8 && wrap_q == 3'd4) begin
      temp = sub_out;
    end
    new_word = prev_w ^ temp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    illegal  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (key_len == 2'd3) begin
            illegal = 1'b1;
          end else begin
            accept   = 1'b1;
            state_nx = LOAD;
          end
        end
      end
      LOAD:    state_nx = EXPAND;
      EXPAND:  if (last_word) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nk_q       <= '0;
      nr_q       <= '0;
      key_q      <= '0;
      i_q        <= '0;
      wrap_q     <= '0;
      rcon_q     <= 8'h01;
      for (int k = 0; k < MAX_KEY_WORDS; k++) win_q[k] <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      err        <= 1'b0;
      num_rounds <= '0;
    end else begin
      busy <= (state_nx == LOAD) || (state_nx == EXPAND);
      done <= 1'b0;
      err  <= illegal;
      if (accept) begin
        nk_q       <= 4'd4 + {1'b0, key_len, 1'b0};
        nr_q       <= 4'd10 + {1'b0, key_len, 1'b0};
        key_q      <= cipher_key;
        keys_valid <= 1'b0;
        num_rounds <= '0;
      end
      case (state)
        LOAD: begin
          i_q    <= 6'(nk_q);
          wrap_q <= '0;
          rcon_q <= 8'h01;
          for (int k = 0; k < MAX_KEY_WORDS; k++) win_q[k] <= key_w[nk_m1 - 3'(k)];
        end
        EXPAND: begin
          win_q[0] <= new_word;
          for (int k = MAX_KEY_WORDS-1; k > 0; k--) win_q[k] <= win_q[k-1];
          i_q    <= i_q + 6'd1;
          wrap_q <= (wrap_q == nk_m1) ? 3'd0 : wrap_q + 3'd1;
          if (wrap_q == 3'd0) begin
            rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          end
          // done/keys_valid are registered here so they are high during the DONE cycle.
          if (last_word) begin
            done       <= 1'b1;
            keys_valid <= 1'b1;
            num_rounds <= nr_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Word store contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      for (int j = 0; j < MAX_KEY_WORDS; j++) begin
        if (4'(j) < nk_q) mem[j] <= key_w[j];
      end
    end else if (state == EXPAND) begin
      mem[i_q] <= new_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_data <= '0;
    end else if (keys_valid && rk_idx <= num_rounds) begin
      rk_data <= {mem[{rk_idx, 2'd0}], mem[{rk_idx, 2'd1}], mem[{rk_idx, 2'd2}], mem[{rk_idx, 2'd3}]};
    end else begin
      rk_data <= '0;
    end
  end

endmodule
